// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         ARID_W         = 4;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past the last
// grant and wraps, so every requester is reached within NUM_REQ bursts.
// The rotation pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  // First requester found in rotation order after the last grant wins
  always_comb begin : pick
    int cand;
    cand        = 0;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(i_last_grant) + k) % NUM_REQ;
      if (!o_any && i_req[IDX_W'(cand)]) begin
        o_any                    = 1'b1;
        o_grant_idx              = IDX_W'(cand);
        o_grant_oh[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin sharing of one AXI read master among NUM_REQ burst requesters.
// One burst outstanding at a time; R beats are steered to the grant owner.
// Optional R-channel watchdog: define AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_BYTE_WIDTH = 32,
  parameter int DATA_BYTE_SHIFT = 5,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int DATA_BIT_WIDTH = DATA_BYTE_WIDTH * 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*32-1:0]     i_req_addr,
  input  logic [NUM_REQ*8-1:0]      i_req_len,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_BIT_WIDTH-1:0] o_rd_data,
  output logic [NUM_REQ-1:0]        o_rd_valid,
  output logic                      o_rd_last,
  output logic                      o_rd_err,
  output logic                      o_busy,
  output logic                      o_stray_err,
  output logic                      o_timeout_err,
  output logic [ARID_W-1:0]         o_axi_arid,
  output logic [31:0]               o_axi_araddr,
  output logic [7:0]                o_axi_arlen,
  output logic [2:0]                o_axi_arsize,
  output logic [1:0]                o_axi_arburst,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  input  logic [ARID_W-1:0]         i_axi_rid,
  input  logic [DATA_BIT_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rlast,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last_grant;
  logic [31:0]        r_araddr;
  logic [7:0]         r_arlen;
  logic [ARID_W-1:0]  r_arid;
  logic               r_arvalid;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [7:0]         r_beat_cnt;
  logic               r_stray_err;
  logic               r_timeout_err;

  logic [NUM_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_any;
  logic [31:0]        w_win_addr;
  logic [7:0]         w_win_len;
  logic               w_in_data;
  logic               w_rid_match;
  logic               w_beat;
  logic               w_stray;
  // Beat count has no functional consumer (RLAST ends the burst); kept for debug probes.
  logic [7:0]         w_beat_cnt_unused;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_idle_cnt;
`else
  logic [15:0] w_timeout_unused;
  assign w_timeout_unused = 16'(TIMEOUT_CYCLES);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_win_oh),
    .o_grant_idx  (w_win_idx),
    .o_any        (w_win_any)
  );

  assign w_win_addr        = i_req_addr[int'(w_win_idx)*32 +: 32];
  assign w_win_len         = i_req_len[int'(w_win_idx)*8 +: 8];
  assign w_beat_cnt_unused = r_beat_cnt;

  // Beat qualification: only beats tagged with the current grant are forwarded
  assign w_in_data   = (r_state == ST_DATA);
  assign w_rid_match = (i_axi_rid == ARID_W'(r_grant));
  assign w_beat      = w_in_data && i_axi_rvalid && w_rid_match;
  assign w_stray     = w_in_data && i_axi_rvalid && !w_rid_match;

  // Controller: request pick, AR handshake, R beat tracking, sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_arid        <= '0;
      r_arvalid     <= 1'b0;
      r_req_ready   <= '0;
      r_beat_cnt    <= '0;
      r_stray_err   <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      r_idle_cnt    <= '0;
`endif
    end else begin
      r_req_ready <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_state     <= ST_ADDR;
            r_grant     <= w_win_idx;
            r_araddr    <= w_win_addr;
            r_arlen     <= w_win_len;
            r_arid      <= ARID_W'(w_win_idx);
            r_arvalid   <= 1'b1;
            r_req_ready <= w_win_oh;
          end
        end
        ST_ADDR: begin
          // arvalid is held high for the whole ADDR state, so arready alone completes it
          if (i_axi_arready) begin
            r_state    <= ST_DATA;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arid     <= '0;
            r_beat_cnt <= '0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
          end
        end
        ST_DATA: begin
          if (w_stray) begin
            r_stray_err <= 1'b1;
          end
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (i_axi_rlast) begin
              r_state      <= ST_IDLE;
              r_last_grant <= r_grant;
            end
          end
`ifdef AXI_RD_ARB_TIMEOUT_EN
          // Watchdog only restarts on R-channel activity; a silent slave aborts the burst
          if (i_axi_rvalid) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == TIMEOUT_LAST) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-requester beat strobe
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rd_valid
      assign o_rd_valid[gi] = w_beat && (r_grant == IDX_W'(gi));
    end
  endgenerate

  assign o_rd_data     = w_beat ? i_axi_rdata : '0;
  assign o_rd_last     = w_beat && i_axi_rlast;
  assign o_rd_err      = w_beat && (i_axi_rresp != AXI_RESP_OKAY);
  assign o_axi_rready  = w_in_data;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_req_ready   = r_req_ready;
  assign o_stray_err   = r_stray_err;
  assign o_timeout_err = r_timeout_err;
  assign o_axi_arid    = r_arid;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_arlen   = r_arlen;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_arsize  = 3'(DATA_BYTE_SHIFT);
  assign o_axi_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (3 requesters, 32-bit data).
// Optional watchdog path exercised when AXI_RD_ARB_TIMEOUT_EN is defined.
module tb_axi_rd_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req_valid;
  logic [N*32-1:0] i_req_addr;
  logic [N*8-1:0]  i_req_len;
  logic [N-1:0]    o_req_ready;
  logic [DW-1:0]   o_rd_data;
  logic [N-1:0]    o_rd_valid;
  logic            o_rd_last, o_rd_err, o_busy, o_stray_err, o_timeout_err;
  logic [3:0]      o_axi_arid;
  logic [31:0]     o_axi_araddr;
  logic [7:0]      o_axi_arlen;
  logic [2:0]      o_axi_arsize;
  logic [1:0]      o_axi_arburst;
  logic            o_axi_arvalid, i_axi_arready;
  logic [3:0]      i_axi_rid;
  logic [DW-1:0]   i_axi_rdata;
  logic [1:0]      i_axi_rresp;
  logic            i_axi_rlast, i_axi_rvalid, o_axi_rready;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .NUM_REQ(N), .DATA_BYTE_WIDTH(4), .DATA_BYTE_SHIFT(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .o_req_ready(o_req_ready), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_rd_last(o_rd_last), .o_rd_err(o_rd_err), .o_busy(o_busy),
    .o_stray_err(o_stray_err), .o_timeout_err(o_timeout_err),
    .o_axi_arid(o_axi_arid), .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen),
    .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .i_axi_rid(i_axi_rid), .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
    .i_axi_rlast(i_axi_rlast), .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: rotation pointer plus each requester's programmed burst
  int          model_last;
  logic [31:0] m_addr [N];
  logic [7:0]  m_len  [N];

  // Observations gathered by the burst driver
  logic [31:0] cap_araddr;
  logic [7:0]  cap_arlen;
  logic [3:0]  cap_arid;
  logic [2:0]  cap_arsize;
  logic [1:0]  cap_arburst;
  logic [N-1:0] cap_ready_or;
  logic        cap_busy_after;
  int cap_ar_unstable, cap_ar_cycles, cap_ready_cycles, cap_beats, cap_wrong_strobe;
  int cap_data_bad, cap_last_at, cap_last_cnt, cap_err_at, cap_err_cnt, cap_stray_fwd;

  // Round-robin rule: first requesting index after the previous winner, wrapping
  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len);
    m_addr[i] = addr;
    m_len[i]  = len;
    i_req_addr[i*32 +: 32] = addr;
    i_req_len[i*8 +: 8]    = len;
  endtask

  // Plays slave and requesters for one burst starting from IDLE; records what it sees
  task automatic do_burst(input int ar_wait, input int nbeats, input int stray_at, input int err_at);
    int b;
    logic [DW-1:0] d;
    logic [N-1:0] exp_oh;
    cap_ar_unstable = 0; cap_ar_cycles = 0; cap_ready_cycles = 0; cap_ready_or = '0;
    cap_beats = 0; cap_wrong_strobe = 0; cap_data_bad = 0; cap_last_at = -1; cap_last_cnt = 0;
    cap_err_at = -1; cap_err_cnt = 0; cap_stray_fwd = 0;
    tick();
    cap_araddr = o_axi_araddr; cap_arlen = o_axi_arlen; cap_arid = o_axi_arid;
    cap_arsize = o_axi_arsize; cap_arburst = o_axi_arburst;
    for (int w = 0; w <= ar_wait; w++) begin
      i_axi_arready = (w == ar_wait);
      #1;
      if (o_axi_arvalid !== 1'b1 || o_axi_araddr !== cap_araddr || o_axi_arlen !== cap_arlen
          || o_axi_arid !== cap_arid) cap_ar_unstable++;
      cap_ar_cycles++;
      if (o_req_ready != '0) cap_ready_cycles++;
      cap_ready_or = cap_ready_or | o_req_ready;
      i_req_valid  = i_req_valid & ~o_req_ready;
      tick();
    end
    i_axi_arready = 1'b0;
    exp_oh = N'(1) << cap_arid;
    b = 0;
    for (int s = 0; (b < nbeats) && (s < 4*nbeats + 8); s++) begin
      if (s == stray_at) begin
        i_axi_rvalid = 1'b1; i_axi_rid = 4'd3; i_axi_rlast = 1'b1;
        i_axi_rdata = $urandom; i_axi_rresp = 2'b00;
        #1;
        if (o_rd_valid != '0 || o_rd_last) cap_stray_fwd++;
      end else if ($urandom_range(0, 3) == 0) begin
        i_axi_rvalid = 1'b0; i_axi_rlast = 1'b0;
        #1;
        if (o_rd_valid != '0) cap_wrong_strobe++;
      end else begin
        d = $urandom;
        i_axi_rvalid = 1'b1; i_axi_rid = cap_arid; i_axi_rdata = d;
        i_axi_rlast = (b == nbeats - 1); i_axi_rresp = (b == err_at) ? 2'b10 : 2'b00;
        #1;
        if (o_rd_valid === exp_oh) cap_beats++; else cap_wrong_strobe++;
        if (o_rd_data !== d) cap_data_bad++;
        if (o_rd_last) begin cap_last_cnt++; cap_last_at = b; end
        if (o_rd_err) begin cap_err_cnt++; cap_err_at = b; end
        b++;
      end
      if (o_req_ready != '0) cap_ready_cycles++;
      tick();
    end
    i_axi_rvalid = 1'b0; i_axi_rlast = 1'b0; i_axi_rresp = 2'b00;
    #1;
    cap_busy_after = o_busy;
    $display("burst: arid=%0d araddr=%08h arlen=%0d ar_wait=%0d beats=%0d last_at=%0d",
             cap_arid, cap_araddr, cap_arlen, ar_wait, cap_beats, cap_last_at);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_valid = '1;
    tick(); tick();
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_axi_arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", o_axi_arvalid); else n_pass++;
    n_total++; if (o_req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", o_req_ready); else n_pass++;
    n_total++; if ({o_stray_err, o_timeout_err, o_axi_rready} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {o_stray_err, o_timeout_err, o_axi_rready}); else n_pass++;
    n_total++; if (o_axi_araddr !== 32'd0 || o_axi_arlen !== 8'd0 || o_axi_arid !== 4'd0)
      $display("FAIL reset_ar_fields: got %h/%h/%h want 0", o_axi_araddr, o_axi_arlen, o_axi_arid); else n_pass++;
    i_req_valid = '0;
    rst = 1'b0;
    model_last = N - 1;
    tick();
  endtask

  task automatic test_single();
    int exp;
    set_req(0, 32'h1000_0000, 8'd15);
    i_req_valid = 3'b001;
    exp = rr_pick(i_req_valid, model_last);
    do_burst(0, 16, -1, -1);
    n_total++; if (cap_arid !== 4'(exp)) $display("FAIL single_arid: got %0d want %0d", cap_arid, exp); else n_pass++;
    n_total++; if (cap_araddr !== 32'h1000_0000) $display("FAIL single_araddr: got %h want 10000000", cap_araddr); else n_pass++;
    n_total++; if (cap_arlen !== 8'd15) $display("FAIL single_arlen: got %0d want 15", cap_arlen); else n_pass++;
    n_total++; if (cap_arsize !== 3'd2 || cap_arburst !== 2'b01)
      $display("FAIL single_size_burst: got %0d/%b want 2/01", cap_arsize, cap_arburst); else n_pass++;
    n_total++; if (cap_beats !== 16 || cap_wrong_strobe !== 0)
      $display("FAIL single_beats: got %0d (wrong %0d) want 16 (0)", cap_beats, cap_wrong_strobe); else n_pass++;
    n_total++; if (cap_data_bad !== 0) $display("FAIL single_data: got %0d bad beats want 0", cap_data_bad); else n_pass++;
    n_total++; if (cap_last_at !== 15 || cap_last_cnt !== 1)
      $display("FAIL single_last: got at %0d x%0d want at 15 x1", cap_last_at, cap_last_cnt); else n_pass++;
    n_total++; if (cap_busy_after !== 1'b0) $display("FAIL single_busy_after: got %b want 0", cap_busy_after); else n_pass++;
    n_total++; if (cap_ready_or !== 3'b001 || cap_ready_cycles !== 1)
      $display("FAIL single_ready: got %b x%0d want 001 x1", cap_ready_or, cap_ready_cycles); else n_pass++;
    model_last = exp;
  endtask

  // Two requesters contend three times; bursts run back to back
  task automatic test_back_to_back();
    int exp;
    set_req(0, 32'h2000_0000, 8'd3);
    set_req(1, 32'h3000_0040, 8'd2);
    for (int r = 0; r < 3; r++) begin
      i_req_valid = i_req_valid | 3'b011;
      exp = rr_pick(i_req_valid, model_last);
      do_burst($urandom_range(0, 2), int'(m_len[exp]) + 1, -1, -1);
      n_total++; if (cap_arid !== 4'(exp)) $display("FAIL contend_arid[%0d]: got %0d want %0d", r, cap_arid, exp); else n_pass++;
      n_total++; if (cap_araddr !== m_addr[exp]) $display("FAIL contend_araddr[%0d]: got %h want %h", r, cap_araddr, m_addr[exp]); else n_pass++;
      n_total++; if (cap_ready_or !== (N'(1) << exp) || cap_ready_cycles !== 1)
        $display("FAIL contend_ready[%0d]: got %b x%0d want %b x1", r, cap_ready_or, cap_ready_cycles, N'(1) << exp); else n_pass++;
      n_total++; if (cap_ar_unstable !== 0) $display("FAIL contend_arvalid[%0d]: got %0d bad cycles want 0", r, cap_ar_unstable); else n_pass++;
      model_last = exp;
    end
    i_req_valid = '0;
  endtask

  task automatic test_backpressure();
    int exp;
    set_req(2, 32'h4000_1000, 8'd3);
    i_req_valid = 3'b100;
    exp = rr_pick(i_req_valid, model_last);
    do_burst(5, 4, -1, -1);
    n_total++; if (cap_arid !== 4'(exp)) $display("FAIL bp_arid: got %0d want %0d", cap_arid, exp); else n_pass++;
    n_total++; if (cap_ar_unstable !== 0 || cap_ar_cycles !== 6)
      $display("FAIL bp_ar_stable: got %0d bad of %0d want 0 of 6", cap_ar_unstable, cap_ar_cycles); else n_pass++;
    n_total++; if (cap_ready_cycles !== 1) $display("FAIL bp_ready_pulses: got %0d want 1", cap_ready_cycles); else n_pass++;
    n_total++; if (cap_beats !== 4) $display("FAIL bp_beats: got %0d want 4", cap_beats); else n_pass++;
    model_last = exp;
  endtask

  task automatic test_stray();
    int exp;
    n_total++; if (o_stray_err !== 1'b0) $display("FAIL stray_pre: got %b want 0", o_stray_err); else n_pass++;
    set_req(0, 32'h1000_0100, 8'd5);
    i_req_valid = 3'b001;
    exp = rr_pick(i_req_valid, model_last);
    do_burst(0, 6, 2, -1);
    n_total++; if (cap_arid !== 4'(exp)) $display("FAIL stray_arid: got %0d want %0d", cap_arid, exp); else n_pass++;
    n_total++; if (cap_stray_fwd !== 0) $display("FAIL stray_forwarded: got %0d want 0", cap_stray_fwd); else n_pass++;
    n_total++; if (o_stray_err !== 1'b1) $display("FAIL stray_flag: got %b want 1", o_stray_err); else n_pass++;
    n_total++; if (cap_beats !== 6 || cap_last_at !== 5)
      $display("FAIL stray_beats: got %0d last %0d want 6 last 5", cap_beats, cap_last_at); else n_pass++;
    model_last = exp;
  endtask

  task automatic test_rd_err();
    int exp;
    set_req(1, 32'h5000_0000, 8'd4);
    i_req_valid = 3'b010;
    exp = rr_pick(i_req_valid, model_last);
    do_burst(1, 5, -1, 2);
    n_total++; if (cap_err_cnt !== 1 || cap_err_at !== 2)
      $display("FAIL rd_err: got x%0d at %0d want x1 at 2", cap_err_cnt, cap_err_at); else n_pass++;
    n_total++; if (o_stray_err !== 1'b1) $display("FAIL stray_sticky: got %b want 1", o_stray_err); else n_pass++;
    model_last = exp;
  endtask

  task automatic test_random();
    int exp;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!i_req_valid[i]) set_req(i, $urandom, 8'($urandom_range(0, 6)));
      end
      i_req_valid = i_req_valid | N'($urandom_range(1, 7));
      exp = rr_pick(i_req_valid, model_last);
      do_burst($urandom_range(0, 3), int'(m_len[exp]) + 1, -1, -1);
      n_total++; if (cap_arid !== 4'(exp)) $display("FAIL rand_arid[%0d]: got %0d want %0d", it, cap_arid, exp); else n_pass++;
      n_total++; if (cap_araddr !== m_addr[exp] || cap_arlen !== m_len[exp])
        $display("FAIL rand_ar[%0d]: got %h/%0d want %h/%0d", it, cap_araddr, cap_arlen, m_addr[exp], m_len[exp]); else n_pass++;
      n_total++; if (cap_beats !== int'(m_len[exp]) + 1 || cap_last_at !== int'(m_len[exp]) || cap_data_bad !== 0)
        $display("FAIL rand_beats[%0d]: got %0d last %0d bad %0d want %0d last %0d bad 0",
                 it, cap_beats, cap_last_at, cap_data_bad, int'(m_len[exp]) + 1, m_len[exp]); else n_pass++;
      model_last = exp;
    end
    i_req_valid = '0;
    tick();
  endtask

  // Slave goes silent after one beat
  task automatic test_timeout();
    int exp;
    int c;
    set_req(0, 32'h6000_0000, 8'd7);
    i_req_valid = 3'b001;
    exp = rr_pick(i_req_valid, model_last);
    tick();
    i_req_valid = '0;
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b1; i_axi_rid = 4'(exp); i_axi_rlast = 1'b0; i_axi_rdata = $urandom;
    tick();
    i_axi_rvalid = 1'b0;
    c = 0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
    while (o_busy && c < 4*TO) begin
      tick();
      c++;
    end
    n_total++; if (c !== TO) $display("FAIL timeout_cycles: got %0d want %0d", c, TO); else n_pass++;
    n_total++; if (o_timeout_err !== 1'b1) $display("FAIL timeout_flag: got %b want 1", o_timeout_err); else n_pass++;
    $display("timeout: abort after %0d idle cycles", c);
`else
    for (int k = 0; k < TO + 16; k++) tick();
    n_total++; if (o_busy !== 1'b1 || o_timeout_err !== 1'b0)
      $display("FAIL no_timeout: got busy %b err %b want 1 0", o_busy, o_timeout_err); else n_pass++;
    i_axi_rvalid = 1'b1; i_axi_rid = 4'(exp); i_axi_rlast = 1'b1;
    tick();
    i_axi_rvalid = 1'b0; i_axi_rlast = 1'b0;
    #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL late_last_busy: got %b want 0", o_busy); else n_pass++;
    model_last = exp;
    $display("stall: burst held %0d cycles then completed", TO + 16);
`endif
  endtask

  task automatic test_reset_mid_burst();
    int exp;
    set_req(1, 32'h7000_0000, 8'd7);
    i_req_valid = 3'b010;
    tick();
    i_req_valid = '0;
    i_axi_arready = 1'b1;
    tick();
    i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b1; i_axi_rid = 4'd1; i_axi_rlast = 1'b0; i_axi_rdata = 32'hA5A5_5A5A;
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (o_rd_valid !== '0 || o_rd_last !== 1'b0 || o_rd_data !== '0)
      $display("FAIL mid_rst_rd: got %b/%b/%h want 0", o_rd_valid, o_rd_last, o_rd_data); else n_pass++;
    n_total++; if (o_busy !== 1'b0 || o_axi_rready !== 1'b0)
      $display("FAIL mid_rst_state: got busy %b rready %b want 0 0", o_busy, o_axi_rready); else n_pass++;
    n_total++; if (o_stray_err !== 1'b0 || o_timeout_err !== 1'b0)
      $display("FAIL mid_rst_sticky: got %b %b want 0 0", o_stray_err, o_timeout_err); else n_pass++;
    i_axi_rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_last = N - 1;
    tick();
    set_req(0, 32'h0000_0800, 8'd1);
    set_req(1, 32'h0000_0900, 8'd1);
    set_req(2, 32'h0000_0A00, 8'd1);
    i_req_valid = 3'b111;
    exp = rr_pick(i_req_valid, model_last);
    do_burst(0, 2, -1, -1);
    n_total++; if (cap_arid !== 4'(exp)) $display("FAIL post_rst_grant: got %0d want %0d", cap_arid, exp); else n_pass++;
    i_req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = '0; i_req_addr = '0; i_req_len = '0;
    i_axi_arready = 1'b0; i_axi_rid = '0; i_axi_rdata = '0;
    i_axi_rresp = 2'b00; i_axi_rlast = 1'b0; i_axi_rvalid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stray();
    test_rd_err();
    test_random();
    test_timeout();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
